tt_mux_slot_ctrl: RTL and testbench

Parametrised multi-project slot controller. It time-shares one set of Tiny Tapeout pad buses (packed iw/ow format) among NUM_SLOTS project wrappers.
- Exactly one slot is enabled at a time.
- Inputs to all other slots are held at zero.
- On every switch it runs a blanking interval, then a forced project-reset interval.
- The selected slot's ow bus is registered back to the pads.

It sits between the pad ring and the array of per-project wrappers.

---
 rtl/tt_mux_slot_ctrl.sv | 146 ++++++++++++++
 tb/tb_tt_mux_slot_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_mux_slot_ctrl.sv
// Multi-project slot controller: time-shares one packed Tiny Tapeout pad bus among
// NUM_SLOTS wrappers, with a blanking gap and a forced project reset on every switch.
module tt_mux_slot_ctrl #(
  parameter int NUM_SLOTS    = 16,
  parameter int IW_W         = 18,
  parameter int OW_W         = 24,
  parameter int BLANK_CYCLES = 4,
  parameter int RST_CYCLES   = 8,
  localparam int SEL_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sel_valid,
  output logic                      sel_ready,
  input  logic [SEL_W-1:0]          sel_addr,
  output logic                      sel_err,
  input  logic [IW_W-1:0]           pad_iw,
  output logic [OW_W-1:0]           pad_ow,
  output logic [NUM_SLOTS-1:0]      slot_ena,
  output logic [IW_W-1:0]           slot_iw,
  input  logic [NUM_SLOTS*OW_W-1:0] slot_ow,
  output logic                      active_valid,
  output logic [SEL_W-1:0]          active_sel
);

  localparam int CNT_MAX = (BLANK_CYCLES > RST_CYCLES) ? BLANK_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ADDR_N  = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, BLANK, RST, ACTIVE} state_t;

  // Table of legal slot indices; avoids a range compare that is constant when
  // NUM_SLOTS is a power of two.
  function automatic logic [ADDR_N-1:0] build_mask();
    logic [ADDR_N-1:0] m;
    for (int i = 0; i < ADDR_N; i++) m[i] = (i < NUM_SLOTS);
    return m;
  endfunction

  localparam logic [ADDR_N-1:0] SEL_MASK = build_mask();

  state_t                state, next_state;
  logic [CNT_W-1:0]      cnt, next_cnt;
  logic [SEL_W-1:0]      next_sel;
  logic                  next_err;
  logic [NUM_SLOTS-1:0]  next_ena;
  logic [OW_W-1:0]       next_pad_ow;
  logic                  xfer;
  logic [OW_W-1:0]       ow_arr [ADDR_N];

  // Unused index codes read as zero so the output mux is always in range.
  for (genvar k = 0; k < ADDR_N; k++) begin : g_ow
    if (k < NUM_SLOTS) begin : g_used
      assign ow_arr[k] = slot_ow[k*OW_W +: OW_W];
    end else begin : g_unused
      assign ow_arr[k] = '0;
    end
  end

  assign sel_ready    = (state == IDLE) || (state == ACTIVE);
  assign active_valid = (state == ACTIVE);
  assign xfer         = sel_valid && sel_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    next_state = state;
    next_cnt   = cnt;
    next_sel   = active_sel;
    next_err   = sel_err;
    unique case (state)
      IDLE, ACTIVE: begin
        if (xfer) begin
          next_cnt = '0;
          if (SEL_MASK[sel_addr]) begin
            next_state = BLANK;
            next_sel   = sel_addr;
            next_err   = 1'b0;
          end else begin
            next_state = IDLE;
            next_err   = 1'b1;
          end
        end
      end
      BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          next_state = RST;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      RST: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          next_state = ACTIVE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      default: next_state = IDLE;
    endcase

    next_ena = '0;
    if (next_state == RST || next_state == ACTIVE)
      next_ena = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << next_sel;

    // Only forward wrapper outputs while staying in ACTIVE, so a switch
    // blanks the pads on the very first BLANK cycle.
    next_pad_ow = '0;
    if (state == ACTIVE && next_state == ACTIVE)
      next_pad_ow = ow_arr[active_sel];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      active_sel <= '0;
      sel_err    <= 1'b0;
      slot_ena   <= '0;
      pad_ow     <= '0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      active_sel <= next_sel;
      sel_err    <= next_err;
      slot_ena   <= next_ena;
      pad_ow     <= next_pad_ow;
    end
  end

  // Input gating depends only on registered state: project rst_n is held low
  // while the freshly enabled slot is in its reset window.
  always_comb begin
    slot_iw = '0;
    unique case (state)
      RST:     slot_iw = {pad_iw[IW_W-1:2], 1'b0, pad_iw[0]};
      ACTIVE:  slot_iw = pad_iw;
      default: slot_iw = '0;
    endcase
  end

endmodule

// File: tb/tb_tt_mux_slot_ctrl.sv
// Directed bench for tt_mux_slot_ctrl: default 16-slot instance plus a 12-slot
// instance for out-of-range select handling.
module tb_tt_mux_slot_ctrl;

  localparam int IW_W = 18;
  localparam int OW_W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [IW_W-1:0] pad_iw;

  logic              sel_valid_a, sel_ready_a, sel_err_a, active_valid_a;
  logic [3:0]        sel_addr_a, active_sel_a;
  logic [OW_W-1:0]   pad_ow_a;
  logic [15:0]       slot_ena_a;
  logic [IW_W-1:0]   slot_iw_a;
  logic [16*OW_W-1:0] slot_ow_a;

  logic              sel_valid_b, sel_ready_b, sel_err_b, active_valid_b;
  logic [3:0]        sel_addr_b, active_sel_b;
  logic [OW_W-1:0]   pad_ow_b;
  logic [11:0]       slot_ena_b;
  logic [IW_W-1:0]   slot_iw_b;
  logic [12*OW_W-1:0] slot_ow_b;

  int n_checks = 0;
  int n_pass   = 0;
  int glitches = 0;
  logic [15:0] prev_ena = '0;

  always #5 clk = ~clk;

  tt_mux_slot_ctrl dut_a (
    .clk(clk), .rst_n(rst_n),
    .sel_valid(sel_valid_a), .sel_ready(sel_ready_a), .sel_addr(sel_addr_a),
    .sel_err(sel_err_a), .pad_iw(pad_iw), .pad_ow(pad_ow_a),
    .slot_ena(slot_ena_a), .slot_iw(slot_iw_a), .slot_ow(slot_ow_a),
    .active_valid(active_valid_a), .active_sel(active_sel_a)
  );

  tt_mux_slot_ctrl #(.NUM_SLOTS(12)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .sel_valid(sel_valid_b), .sel_ready(sel_ready_b), .sel_addr(sel_addr_b),
    .sel_err(sel_err_b), .pad_iw(pad_iw), .pad_ow(pad_ow_b),
    .slot_ena(slot_ena_b), .slot_iw(slot_iw_b), .slot_ow(slot_ow_b),
    .active_valid(active_valid_b), .active_sel(active_sel_b)
  );

  // Two different one-hot enables must never sit on adjacent cycles.
  always @(negedge clk) begin
    if (prev_ena != 16'h0 && slot_ena_a != 16'h0 && slot_ena_a != prev_ena)
      glitches <= glitches + 1;
    prev_ena <= slot_ena_a;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full switch timeline on instance A; transfer happens on the first edge.
  task automatic run_switch_a(input logic [3:0] addr, input logic [15:0] exp_ena);
    sel_addr_a  = addr;
    sel_valid_a = 1'b1;
    tick();
    sel_valid_a = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("blank_ena", 64'(slot_ena_a), 64'(16'h0));
      check("blank_iw", 64'(slot_iw_a), 64'(18'h0));
      check("blank_ready", 64'(sel_ready_a), 64'(1'b0));
      check("blank_pad_ow", 64'(pad_ow_a), 64'(24'h0));
      tick();
    end
    for (int c = 5; c <= 12; c++) begin
      check("rst_ena", 64'(slot_ena_a), 64'(exp_ena));
      check("rst_iw", 64'(slot_iw_a), 64'(pad_iw & 18'h3FFFD));
      check("rst_pad_ow", 64'(pad_ow_a), 64'(24'h0));
      check("rst_valid", 64'(active_valid_a), 64'(1'b0));
      tick();
    end
    check("act_valid", 64'(active_valid_a), 64'(1'b1));
    check("act_first_pad_ow", 64'(pad_ow_a), 64'(24'h0));
    check("act_iw", 64'(slot_iw_a), 64'(pad_iw));
    check("act_sel", 64'(active_sel_a), 64'(addr));
    tick();
    check("act_pad_ow", 64'(pad_ow_a), 64'(slot_ow_a[addr*OW_W +: OW_W]));
  endtask

  initial begin
    sel_valid_a = 1'b0; sel_addr_a = '0;
    sel_valid_b = 1'b0; sel_addr_b = '0;
    pad_iw = 18'h3FFFF;
    for (int k = 0; k < 16; k++) slot_ow_a[k*OW_W +: OW_W] = 24'(32'hA00000 + k);
    for (int k = 0; k < 12; k++) slot_ow_b[k*OW_W +: OW_W] = 24'(32'hB00000 + k);

    // Reset state, observed before any clock edge has occurred.
    #2 rst_n = 1'b0;
    #2;
    check("rst_slot_ena", 64'(slot_ena_a), 64'(16'h0));
    check("rst_slot_iw", 64'(slot_iw_a), 64'(18'h0));
    check("rst_pad_ow", 64'(pad_ow_a), 64'(24'h0));
    check("rst_sel_ready", 64'(sel_ready_a), 64'(1'b1));
    check("rst_active_valid", 64'(active_valid_a), 64'(1'b0));
    check("rst_sel_err", 64'(sel_err_a), 64'(1'b0));
    check("rst_active_sel", 64'(active_sel_a), 64'(4'h0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_iw", 64'(slot_iw_a), 64'(18'h0));

    // Switch to slot 3.
    pad_iw = 18'h15A3E;
    run_switch_a(4'd3, 16'h0008);

    // ACTIVE pass-through and output mux.
    pad_iw = 18'h2A5F5;
    #1;
    check("pass_iw", 64'(slot_iw_a), 64'(18'h2A5F5));
    slot_ow_a[3*OW_W +: OW_W] = 24'hC0FFEE;
    tick();
    check("pass_pad_ow", 64'(pad_ow_a), 64'(24'hC0FFEE));
    slot_ow_a[5*OW_W +: OW_W] = 24'h123456;
    tick();
    check("other_slot_ignored", 64'(pad_ow_a), 64'(24'hC0FFEE));

    // Switch 3 -> 9 with blanking in between.
    run_switch_a(4'd9, 16'h0200);
    check("no_adjacent_onehots", 64'(glitches), 64'(0));

    // sel_valid held through BLANK/RST is ignored until ACTIVE.
    sel_addr_a  = 4'd7;
    sel_valid_a = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      check("hold_ready", 64'(sel_ready_a), 64'(1'b0));
      check("hold_ena", 64'(slot_ena_a), 64'((c <= 4) ? 16'h0 : 16'h0080));
      tick();
    end
    check("hold_act_valid", 64'(active_valid_a), 64'(1'b1));
    check("hold_act_ready", 64'(sel_ready_a), 64'(1'b1));
    check("hold_act_ena", 64'(slot_ena_a), 64'(16'h0080));
    tick();
    check("restart_valid", 64'(active_valid_a), 64'(1'b0));
    check("restart_ena", 64'(slot_ena_a), 64'(16'h0));
    check("restart_ready", 64'(sel_ready_a), 64'(1'b0));
    sel_valid_a = 1'b0;
    for (int i = 0; i < 20 && !active_valid_a; i++) tick();
    check("restart_reach_active", 64'(active_valid_a), 64'(1'b1));
    check("restart_ena_active", 64'(slot_ena_a), 64'(16'h0080));

    // Asynchronous reset in the middle of RST.
    pad_iw = 18'h3FFFF;
    sel_addr_a  = 4'd3;
    sel_valid_a = 1'b1;
    tick();
    sel_valid_a = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("midrst_ena_before", 64'(slot_ena_a), 64'(16'h0008));
    #2 rst_n = 1'b0;
    #1;
    check("async_ena", 64'(slot_ena_a), 64'(16'h0));
    check("async_iw", 64'(slot_iw_a), 64'(18'h0));
    check("async_pad_ow", 64'(pad_ow_a), 64'(24'h0));
    check("async_ready", 64'(sel_ready_a), 64'(1'b1));
    check("async_valid", 64'(active_valid_a), 64'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();

    // Out-of-range select on the 12-slot instance.
    sel_addr_b  = 4'd13;
    sel_valid_b = 1'b1;
    tick();
    sel_valid_b = 1'b0;
    check("b_err_set", 64'(sel_err_b), 64'(1'b1));
    check("b_err_ena", 64'(slot_ena_b), 64'(12'h0));
    check("b_err_pad_ow", 64'(pad_ow_b), 64'(24'h0));
    check("b_err_idle_ready", 64'(sel_ready_b), 64'(1'b1));
    check("b_err_sel_kept", 64'(active_sel_b), 64'(4'd0));
    check("b_err_iw", 64'(slot_iw_b), 64'(18'h0));
    sel_addr_b  = 4'd2;
    sel_valid_b = 1'b1;
    tick();
    sel_valid_b = 1'b0;
    check("b_err_cleared", 64'(sel_err_b), 64'(1'b0));
    check("b_sel2", 64'(active_sel_b), 64'(4'd2));
    check("b_blank_ena", 64'(slot_ena_b), 64'(12'h0));
    for (int i = 0; i < 20 && !active_valid_b; i++) tick();
    check("b_reach_active", 64'(active_valid_b), 64'(1'b1));
    check("b_active_ena", 64'(slot_ena_b), 64'(12'h004));
    tick();
    check("b_pad_ow", 64'(pad_ow_b), 64'(24'hB00002));
    sel_addr_b  = 4'd15;
    sel_valid_b = 1'b1;
    tick();
    sel_valid_b = 1'b0;
    check("b_err_from_active", 64'(sel_err_b), 64'(1'b1));
    check("b_err_active_ena", 64'(slot_ena_b), 64'(12'h0));
    check("b_err_active_pad_ow", 64'(pad_ow_b), 64'(24'h0));
    check("b_err_active_sel", 64'(active_sel_b), 64'(4'd2));
    check("b_err_active_valid", 64'(active_valid_b), 64'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
